// File: rtl/axi_burst_scheduler.sv
// Splits a byte-addressed transfer request into AXI INCR bursts.
// Bursts are capped at 256 beats and never cross a 4 KB boundary. Only one burst is outstanding at a time.
module axi_burst_scheduler #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]      req_length,
    output logic [AXI_ADDR_W-1:0] m_axi_axaddr,
    output logic [7:0]            m_axi_axlen,
    output logic [2:0]            m_axi_axsize,
    output logic [1:0]            m_axi_axburst,
    output logic                  m_axi_axvalid,
    input  logic                  m_axi_axready,
    input  logic                  beat_valid,
    input  logic                  beat_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int BYTES    = AXI_DATA_W / 8;
    localparam int OFFSET_W = $clog2(BYTES);
    // Wide enough for offset+length with carry, and for 256*BYTES at the widest bus.
    localparam int CW       = (LEN_W + 2 > 17) ? LEN_W + 2 : 17;

    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = AXI_ADDR_W'(BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] ADDR = 2'd2;
    localparam logic [1:0] DATA = 2'd3;

    logic [1:0]            state;
    logic [AXI_ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]      remaining;
    logic [CW-1:0]         offset_q;
    logic [8:0]            beats_q;
    logic [8:0]            count_q;
    logic [AXI_ADDR_W-1:0] axaddr_q;
    logic [7:0]            axlen_q;
    logic                  done_q;
    logic                  error_q;

    logic [AXI_ADDR_W-1:0] aligned;
    logic [CW-1:0]         offset_c;
    logic [CW-1:0]         need;
    logic [CW-1:0]         to4k;
    logic [CW-1:0]         beats_c;
    logic [CW-1:0]         burst_bytes;
    logic [CW-1:0]         span;
    logic [CW-1:0]         consumed;
    logic [LEN_W-1:0]      remaining_next;
    logic                  last_beat;

    always_comb begin
        aligned  = cur_addr & ~ADDR_MASK;
        offset_c = CW'(cur_addr & ADDR_MASK);
        need     = (offset_c + CW'(remaining) + CW'(BYTES - 1)) >> OFFSET_W;
        to4k     = (CW'(4096) - CW'(aligned[11:0])) >> OFFSET_W;
        beats_c  = (need < to4k) ? need : to4k;
        if (beats_c > CW'(256)) begin
            beats_c = CW'(256);
        end
        // Bytes of the request actually covered by this burst exclude the leading offset.
        burst_bytes    = CW'(beats_q) << OFFSET_W;
        span           = burst_bytes - offset_q;
        consumed       = (CW'(remaining) < span) ? CW'(remaining) : span;
        remaining_next = remaining - LEN_W'(consumed);
        last_beat      = (count_q == beats_q - 9'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            offset_q  <= '0;
            beats_q   <= '0;
            count_q   <= '0;
            axaddr_q  <= '0;
            axlen_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr  <= req_addr;
                        remaining <= req_length;
                        if (req_length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    axaddr_q <= aligned;
                    axlen_q  <= 8'(beats_c - CW'(1));
                    beats_q  <= 9'(beats_c);
                    offset_q <= offset_c;
                    count_q  <= '0;
                    state    <= ADDR;
                end
                ADDR: begin
                    if (m_axi_axready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (beat_valid) begin
                        if (beat_last != last_beat) begin
                            error_q <= 1'b1;
                        end
                        if (last_beat) begin
                            count_q   <= '0;
                            remaining <= remaining_next;
                            cur_addr  <= axaddr_q + AXI_ADDR_W'(burst_bytes);
                            if (remaining_next == '0) begin
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                state <= CALC;
                            end
                        end else begin
                            count_q <= count_q + 9'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign m_axi_axvalid = (state == ADDR);
    assign m_axi_axaddr  = axaddr_q;
    assign m_axi_axlen   = axlen_q;
    assign m_axi_axsize  = 3'(OFFSET_W);
    assign m_axi_axburst = 2'b01;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Scoreboard bench for axi_burst_scheduler on a 32-bit data bus.
// The stimulus thread queues the expected bursts and event cycles, and a negedge monitor pops and checks them.
module tb_axi_burst_scheduler;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_length;
    logic [AW-1:0] m_axi_axaddr;
    logic [7:0]    m_axi_axlen;
    logic [2:0]    m_axi_axsize;
    logic [1:0]    m_axi_axburst;
    logic          m_axi_axvalid;
    logic          m_axi_axready;
    logic          beat_valid;
    logic          beat_last;
    logic          busy;
    logic          done;
    logic          error;

    axi_burst_scheduler #(
        .AXI_ADDR_W(AW),
        .AXI_DATA_W(DW),
        .LEN_W     (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_length   (req_length),
        .m_axi_axaddr (m_axi_axaddr),
        .m_axi_axlen  (m_axi_axlen),
        .m_axi_axsize (m_axi_axsize),
        .m_axi_axburst(m_axi_axburst),
        .m_axi_axvalid(m_axi_axvalid),
        .m_axi_axready(m_axi_axready),
        .beat_valid   (beat_valid),
        .beat_last    (beat_last),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    int          exp_av[$];
    int          exp_done[$];
    int          plan_beats[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic plan(input logic [31:0] addr, input logic [7:0] len);
        exp_addr.push_back(addr);
        exp_len.push_back(len);
        plan_beats.push_back(int'(len) + 1);
    endtask

    task automatic wait_axvalid(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (m_axi_axvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL axvalid_timeout: got no axvalid, expected one within 1000 cycles");
        end
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int len, input int hold, input int bad_beat);
        int nb;
        int beats;
        bit seen;
        req_addr   = addr;
        req_length = LW'(len);
        req_valid  = 1'b1;
        if (len == 0) exp_done.push_back(cyc + 1);
        else          exp_av.push_back(cyc + 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (len == 0) return;
        nb = plan_beats.size();
        for (int b = 0; b < nb; b++) begin
            beats = plan_beats.pop_front();
            wait_axvalid(seen);
            if (!seen) begin
                plan_beats.delete();
                return;
            end
            check("busy_in_addr", busy, 1);
            check("req_ready_in_addr", req_ready, 0);
            if (b == 0) repeat (hold) @(posedge clk);
            @(posedge clk);
            #1 m_axi_axready = 1'b1;
            @(posedge clk);
            #1 m_axi_axready = 1'b0;
            for (int i = 0; i < beats; i++) begin
                beat_valid = 1'b1;
                if (bad_beat >= 0 && b == 0) beat_last = (i == bad_beat);
                else                         beat_last = (i == beats - 1);
                if (i == beats - 1) begin
                    if (b == nb - 1) exp_done.push_back(cyc + 1);
                    else             exp_av.push_back(cyc + 2);
                end
                @(posedge clk);
                #1;
            end
            beat_valid = 1'b0;
            beat_last  = 1'b0;
        end
    endtask

    // Monitor: every axvalid rise, address handshake and done pulse must match the queued expectation.
    logic        prev_av   = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len  = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wait = 1'b0;
            end else begin
                if (m_axi_axvalid && !prev_av) begin
                    check("axvalid_expected", 64'(exp_av.size() != 0), 1);
                    if (exp_av.size() != 0) check("axvalid_cycle", cyc, exp_av.pop_front());
                end
                if (prev_wait) begin
                    check("hold_axvalid", m_axi_axvalid, 1);
                    check("hold_axaddr", m_axi_axaddr, prev_addr);
                    check("hold_axlen", m_axi_axlen, prev_len);
                end
                if (m_axi_axvalid && m_axi_axready) begin
                    check("burst_expected", 64'(exp_addr.size() != 0), 1);
                    if (exp_addr.size() != 0) begin
                        check("axaddr", m_axi_axaddr, exp_addr.pop_front());
                        check("axlen", m_axi_axlen, exp_len.pop_front());
                        check("axsize", m_axi_axsize, 2);
                        check("axburst", m_axi_axburst, 1);
                    end
                end
                if (done) begin
                    check("done_expected", 64'(exp_done.size() != 0), 1);
                    if (exp_done.size() != 0) check("done_cycle", cyc, exp_done.pop_front());
                end
                prev_wait = m_axi_axvalid && !m_axi_axready;
                prev_addr = m_axi_axaddr;
                prev_len  = m_axi_axlen;
            end
            prev_av = m_axi_axvalid;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_length    = '0;
        m_axi_axready = 1'b0;
        beat_valid    = 1'b0;
        beat_last     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_axvalid", m_axi_axvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_axaddr", m_axi_axaddr, 0);
        check("rst_axlen", m_axi_axlen, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        plan(32'h1000, 8'd3);
        run_xfer(32'h1000, 16, 0, -1);

        plan(32'h1000, 8'd2);
        run_xfer(32'h1002, 8, 0, -1);

        plan(32'h0FF8, 8'd1);
        plan(32'h1000, 8'd1);
        run_xfer(32'h0FF8, 16, 0, -1);

        plan(32'h0000, 8'd255);
        plan(32'h0400, 8'd255);
        run_xfer(32'h0000, 2048, 5, -1);

        run_xfer(32'h2000, 0, 0, -1);
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("error_before", error, 0);
        plan(32'h3000, 8'd3);
        run_xfer(32'h3000, 16, 0, 1);
        @(negedge clk);
        check("error_set", error, 1);
        plan(32'h1000, 8'd0);
        run_xfer(32'h1000, 4, 0, -1);
        @(negedge clk);
        check("error_sticky", error, 1);

        // Reset while the address phase is waiting for axready.
        plan(32'h4000, 8'd7);
        req_addr   = 32'h4000;
        req_length = LW'(32);
        req_valid  = 1'b1;
        exp_av.push_back(cyc + 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_axvalid(seen);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_axvalid", m_axi_axvalid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        exp_addr.delete();
        exp_len.delete();
        plan_beats.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        plan(32'h5000, 8'd0);
        run_xfer(32'h5001, 3, 0, -1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pending_bursts", exp_addr.size(), 0);
        check("pending_axvalid", exp_av.size(), 0);
        check("pending_done", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
